// File: rtl/dice_pkg.sv
// Shared types and constants for the two-player dice round sequencer.
// Also holds the rule that turns a raw generator value into points.
package dice_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ROLL,
    ST_WAIT,
    ST_SCORE,
    ST_DONE
  } state_e;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  localparam logic [2:0] DICE_MIN = 3'd1;
  localparam logic [2:0] DICE_MAX = 3'd6;

  // Out-of-range generator values (0 or 7) are worth nothing.
  function automatic logic [2:0] dice_points(input logic [2:0] d);
    return ((d >= DICE_MIN) && (d <= DICE_MAX)) ? d : 3'd0;
  endfunction

endpackage

// File: rtl/dice_round_ctrl_wait_timer.sv
// Post-throw display wait timer: loaded once per round, counts down, pulses done.
// Runs only between a load and its done pulse; clear aborts it.
module wait_timer #(
  parameter int WAIT_CYCLES       = 36000000,
  parameter int FINAL_WAIT_CYCLES = 60000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic sel_final_i,
  input  logic clear_i,
  output logic done_o
);

  localparam int CNT_W = $clog2(FINAL_WAIT_CYCLES + 1);
  // Counter holds cycles remaining minus one, so done lands on the last wait cycle.
  localparam logic [CNT_W-1:0] LOAD_NORMAL = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOAD_FINAL  = CNT_W'(FINAL_WAIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active_q, active_d;

  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    done_o   = active_q && (cnt_q == '0) && !clear_i;
    if (clear_i) begin
      cnt_d    = '0;
      active_d = 1'b0;
    end else if (load_i) begin
      cnt_d    = sel_final_i ? LOAD_FINAL : LOAD_NORMAL;
      active_d = 1'b1;
    end else if (active_q) begin
      if (cnt_q == '0) begin
        active_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/dice_round_ctrl.sv
// Round sequencer for the two-player dice game: arms the generators, latches
// throws, times the display wait, scores rounds and declares the winner.
module dice_round_ctrl
  import dice_pkg::*;
#(
  parameter int WAIT_CYCLES       = 36000000,
  parameter int FINAL_WAIT_CYCLES = 60000000,
  parameter int NUM_ROUNDS        = 3,
  parameter int SCORE_W           = 3,
  localparam int ROUND_W          = $clog2(NUM_ROUNDS + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start1,
  input  logic               start2,
  input  logic               new_game,
  input  logic [2:0]         dice1,
  input  logic [2:0]         dice2,
  output logic               roll_en,
  output logic [2:0]         lat_dice1,
  output logic [2:0]         lat_dice2,
  output logic               is_wait,
  output logic               is_final,
  output logic [ROUND_W-1:0] round_idx,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               game_over,
  output logic [1:0]         winner
);

  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  state_e             state_q, state_d;
  logic [2:0]         lat1_q, lat1_d, lat2_q, lat2_d;
  logic [SCORE_W-1:0] score1_q, score1_d, score2_q, score2_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic               timer_load, timer_done;
  logic [2:0]         pts1, pts2;

  assign pts1      = dice_points(lat1_q);
  assign pts2      = dice_points(lat2_q);
  assign is_final  = (round_q == ROUND_W'(NUM_ROUNDS - 1));
  assign lat_dice1 = lat1_q;
  assign lat_dice2 = lat2_q;
  assign score1    = score1_q;
  assign score2    = score2_q;
  assign round_idx = round_q;

  wait_timer #(
    .WAIT_CYCLES      (WAIT_CYCLES),
    .FINAL_WAIT_CYCLES(FINAL_WAIT_CYCLES)
  ) u_wait_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (timer_load),
    .sel_final_i(is_final),
    .clear_i    (new_game),
    .done_o     (timer_done)
  );

  always_comb begin
    state_d    = state_q;
    lat1_d     = lat1_q;
    lat2_d     = lat2_q;
    score1_d   = score1_q;
    score2_d   = score2_q;
    round_d    = round_q;
    timer_load = 1'b0;
    roll_en    = 1'b0;
    is_wait    = 1'b1;
    game_over  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start1 && start2) state_d = ST_ROLL;
      end
      ST_ROLL: begin
        roll_en = 1'b1;
        is_wait = 1'b0;
        if (!start1 && !start2) begin
          lat1_d     = dice1;
          lat2_d     = dice2;
          timer_load = 1'b1;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        is_wait = 1'b0;
        if (timer_done) state_d = ST_SCORE;
      end
      ST_SCORE: begin
        if ((pts1 > pts2) && (score1_q != SCORE_MAX)) score1_d = score1_q + SCORE_W'(1);
        if ((pts2 > pts1) && (score2_q != SCORE_MAX)) score2_d = score2_q + SCORE_W'(1);
        round_d = round_q + ROUND_W'(1);
        state_d = is_final ? ST_DONE : ST_IDLE;
      end
      ST_DONE: begin
        game_over = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    // A new game overrides whatever the current state decided.
    if (new_game) begin
      state_d    = ST_IDLE;
      lat1_d     = '0;
      lat2_d     = '0;
      score1_d   = '0;
      score2_d   = '0;
      round_d    = '0;
      timer_load = 1'b0;
    end
  end

  always_comb begin
    winner = WIN_NONE;
    if (game_over) begin
      if (score1_q > score2_q)      winner = WIN_P1;
      else if (score2_q > score1_q) winner = WIN_P2;
      else                          winner = WIN_DRAW;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      lat1_q   <= '0;
      lat2_q   <= '0;
      score1_q <= '0;
      score2_q <= '0;
      round_q  <= '0;
    end else begin
      state_q  <= state_d;
      lat1_q   <= lat1_d;
      lat2_q   <= lat2_d;
      score1_q <= score1_d;
      score2_q <= score2_d;
      round_q  <= round_d;
    end
  end

endmodule

// File: tb/tb_dice_round_ctrl.sv
// Randomized self-checking bench for dice_round_ctrl against a game-level model
// that tracks scores, rounds completed and expected wait lengths.
module tb_dice_round_ctrl;

  localparam int W  = 4;
  localparam int FW = 6;
  localparam int NR = 2;
  localparam int SW = 3;
  localparam int RW = $clog2(NR + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start1 = 1'b0, start2 = 1'b0, new_game = 1'b0;
  logic [2:0]    dice1 = '0, dice2 = '0;
  logic          roll_en, is_wait, is_final, game_over;
  logic [2:0]    lat_dice1, lat_dice2;
  logic [RW-1:0] round_idx;
  logic [SW-1:0] score1, score2;
  logic [1:0]    winner;

  int compared = 0;
  int mismatched = 0;
  int mScore1 = 0, mScore2 = 0, mRounds = 0;

  dice_round_ctrl #(
    .WAIT_CYCLES(W), .FINAL_WAIT_CYCLES(FW), .NUM_ROUNDS(NR), .SCORE_W(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start1(start1), .start2(start2), .new_game(new_game),
    .dice1(dice1), .dice2(dice2), .roll_en(roll_en), .lat_dice1(lat_dice1),
    .lat_dice2(lat_dice2), .is_wait(is_wait), .is_final(is_final), .round_idx(round_idx),
    .score1(score1), .score2(score2), .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int points(input int d);
    return (d >= 1 && d <= 6) ? d : 0;
  endfunction

  function automatic int expWinner();
    if (mRounds < NR) return 0;
    if (mScore1 > mScore2) return 1;
    if (mScore2 > mScore1) return 2;
    return 3;
  endfunction

  // Compares every visible status output with the model at a settled point.
  task automatic checkState(input string tag);
    checkOutput({tag, ".score1"}, score1, mScore1);
    checkOutput({tag, ".score2"}, score2, mScore2);
    checkOutput({tag, ".round"}, round_idx, mRounds);
    checkOutput({tag, ".is_final"}, is_final, (mRounds == NR - 1));
    checkOutput({tag, ".game_over"}, game_over, (mRounds == NR));
    checkOutput({tag, ".winner"}, winner, expWinner());
    checkOutput({tag, ".is_wait"}, is_wait, 1);
    checkOutput({tag, ".roll_en"}, roll_en, 0);
  endtask

  task automatic resetModel();
    mScore1 = 0;
    mScore2 = 0;
    mRounds = 0;
  endtask

  task automatic newGame(input string tag);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    resetModel();
    checkState(tag);
    checkOutput({tag, ".lat1"}, lat_dice1, 0);
    checkOutput({tag, ".lat2"}, lat_dice2, 0);
  endtask

  // Plays one full round from IDLE; start1 is released one cycle before start2.
  task automatic applyStimulus(input string tag, input logic [2:0] d1, input logic [2:0] d2,
                               input int hold);
    int waitCnt;
    int expWait;
    expWait = (mRounds == NR - 1) ? FW : W;
    start1 = 1'b1;
    start2 = 1'b1;
    dice1  = 3'($urandom);
    dice2  = 3'($urandom);
    @(negedge clk);
    checkOutput({tag, ".roll_en"}, roll_en, 1);
    checkOutput({tag, ".is_wait_roll"}, is_wait, 0);
    repeat (hold) @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    checkOutput({tag, ".roll_en_one_btn"}, roll_en, 1);
    start2 = 1'b0;
    dice1  = d1;
    dice2  = d2;
    @(negedge clk);
    dice1 = 3'($urandom);
    dice2 = 3'($urandom);
    checkOutput({tag, ".roll_en_off"}, roll_en, 0);
    checkOutput({tag, ".lat1"}, lat_dice1, d1);
    checkOutput({tag, ".lat2"}, lat_dice2, d2);
    waitCnt = 0;
    while (is_wait == 1'b0 && waitCnt < 100) begin
      waitCnt++;
      @(negedge clk);
    end
    checkOutput({tag, ".wait_len"}, waitCnt, expWait);
    @(negedge clk);
    if (points(d1) > points(d2) && mScore1 < 7) mScore1++;
    if (points(d2) > points(d1) && mScore2 < 7) mScore2++;
    mRounds++;
    checkState(tag);
  endtask

  // Buttons pressed after the game ends must not start anything.
  task automatic pressInDone(input string tag);
    start1 = 1'b1;
    start2 = 1'b1;
    repeat (4) @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
    @(negedge clk);
    checkState(tag);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("reset.roll_en", roll_en, 0);
    checkOutput("reset.is_wait", is_wait, 1);
    rst_n = 1'b1;
    @(negedge clk);
    checkState("reset");

    start1 = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("one_btn.roll_en", roll_en, 0);
    checkOutput("one_btn.is_wait", is_wait, 1);
    start1 = 1'b0;
    @(negedge clk);

    applyStimulus("g1r1", 3'd5, 3'd3, 2);
    applyStimulus("g1r2", 3'd4, 3'd4, 1);
    pressInDone("g1done");

    newGame("ng1");
    applyStimulus("g2r1", 3'd7, 3'd1, 0);
    applyStimulus("g2r2", 3'd2, 3'd2, 0);
    pressInDone("g2done");

    // Abort a final-round wait part way through (timer counted down to 2).
    newGame("ng2");
    applyStimulus("g3r1", 3'd6, 3'd2, 0);
    start1 = 1'b1;
    start2 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
    dice1  = 3'd1;
    dice2  = 3'd6;
    repeat (4) @(negedge clk);
    checkOutput("abort.in_wait", is_wait, 0);
    newGame("abort");
    applyStimulus("g4r1", 3'd3, 3'd5, 1);

    for (int g = 0; g < 6; g++) begin
      newGame("rnd_ng");
      for (int r = 0; r < NR; r++) begin
        applyStimulus("rnd", 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                      int'($urandom_range(0, 3)));
      end
      pressInDone("rnd_done");
    end

    // Asynchronous reset while the generators spin.
    newGame("ng3");
    start1 = 1'b1;
    start2 = 1'b1;
    @(negedge clk);
    checkOutput("async.roll_before", roll_en, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async.roll_en", roll_en, 0);
    checkOutput("async.is_wait", is_wait, 1);
    start1 = 1'b0;
    start2 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    resetModel();
    @(negedge clk);
    checkState("async");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got 0, expected 1");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
